// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_sub_pkg;

  localparam int STATE_W       = 2;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// Optional macro SERIAL_SUB_SIGNED_OVF_EN adds the signed-overflow flag ovf.
interface serial_subtractor_if #(
  parameter int WIDTH = serial_sub_pkg::DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic             ovf;
`endif

`ifdef SERIAL_SUB_SIGNED_OVF_EN
  // Producer/consumer side
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, ovf
  );
  // Subtractor side
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, ovf
  );
`else
  // Producer/consumer side
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow
  );
  // Subtractor side
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow
  );
`endif

endinterface

// File: rtl/serial_sub_bit.sv
// One-bit full subtractor: d = a - b - bin, bout is the borrow out.
module serial_sub_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, one bit per clock.
// Result {borrow, diff} = a - b as a (WIDTH+1)-bit value.
// Optional macro SERIAL_SUB_SIGNED_OVF_EN adds a signed-overflow output.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  state_e           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] a_sr_reg;
  logic [WIDTH-1:0] b_sr_reg;
  logic [WIDTH-1:0] d_sr_reg;
  logic             bor_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             borrow_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic             a_msb_reg;
  logic             b_msb_reg;
  logic             ovf_reg;
`endif

  logic d_bit;
  logic bout_bit;

  // Single shared bit-slice working on the LSBs of the operand shifters
  serial_sub_bit u_bit (
    .a    (a_sr_reg[0]),
    .b    (b_sr_reg[0]),
    .bin  (bor_reg),
    .d    (d_bit),
    .bout (bout_bit)
  );

  // Control FSM plus datapath shifters; all outputs are registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      a_sr_reg      <= '0;
      b_sr_reg      <= '0;
      d_sr_reg      <= '0;
      bor_reg       <= 1'b0;
      diff_reg      <= '0;
      borrow_reg    <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      a_msb_reg     <= 1'b0;
      b_msb_reg     <= 1'b0;
      ovf_reg       <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            a_sr_reg     <= bus.a;
            b_sr_reg     <= bus.b;
            bor_reg      <= 1'b0;
            cnt_reg      <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= RUN;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            a_msb_reg    <= bus.a[WIDTH-1];
            b_msb_reg    <= bus.b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          if (cnt_reg == LAST) begin
            // All bits processed: publish the result in one step
            diff_reg      <= d_sr_reg;
            borrow_reg    <= bor_reg;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            ovf_reg       <= (a_msb_reg != b_msb_reg) &&
                             (d_sr_reg[WIDTH-1] != a_msb_reg);
`endif
          end else begin
            d_sr_reg <= {d_bit, d_sr_reg[WIDTH-1:1]};
            a_sr_reg <= {1'b0, a_sr_reg[WIDTH-1:1]};
            b_sr_reg <= {1'b0, b_sr_reg[WIDTH-1:1]};
            bor_reg  <= bout_bit;
            cnt_reg  <= cnt_reg + CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.diff      = diff_reg;
  assign bus.borrow    = borrow_reg;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  assign bus.ovf       = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks for serial_subtractor (WIDTH=8).
// Signed-overflow checks are compiled in with SERIAL_SUB_SIGNED_OVF_EN.
module tb_serial_subtractor;

  localparam int W = 8;
  localparam int EXP_LAT = W + 1;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   hs_cnt = 0;
  int   ops_done = 0;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every completed output handshake
  always @(posedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) hs_cnt++;
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         br;
    logic         ov;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Full transaction: present operands, measure latency, optionally stall, then accept
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_in, input int stall,
                        output logic [W-1:0] rd, output logic rb, output logic ro,
                        output int lat);
    int n;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    bus.a = ta;
    bus.b = tb_in;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    repeat (stall) begin
      @(posedge clk); #1;
    end
    rd = bus.diff;
    rb = bus.borrow;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ro = bus.ovf;
`else
    ro = 1'b0;
`endif
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    ops_done++;
    $display("op a=%02h b=%02h -> diff=%02h borrow=%0d ovf=%0d lat=%0d", ta, tb_in, rd, rb, ro, lat);
  endtask

  initial begin
    logic [W-1:0] rd;
    logic         rb;
    logic         ro;
    int           lat;
    logic [W:0]   e;
    logic [W-1:0] ra;
    logic [W-1:0] rbv;
    int           n;

    vecs[0] = '{8'h33, 8'h55, 8'hDE, 1'b1, 1'b0};
    vecs[1] = '{8'hF0, 8'h0F, 8'hE1, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vecs[6] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_diff", 32'(bus.diff), 32'd0);
    chk("reset_borrow", 32'(bus.borrow), 32'd0);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    chk("reset_ovf", 32'(bus.ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, 0, rd, rb, ro, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(EXP_LAT));
      chk($sformatf("vec%0d_diff", i), 32'(rd), 32'(vecs[i].d));
      chk($sformatf("vec%0d_borrow", i), 32'(rb), 32'(vecs[i].br));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      chk($sformatf("vec%0d_ovf", i), 32'(ro), 32'(vecs[i].ov));
`endif
      chk($sformatf("vec%0d_in_ready_after", i), 32'(bus.in_ready), 32'd1);
      chk($sformatf("vec%0d_out_valid_after", i), 32'(bus.out_valid), 32'd0);
      chk($sformatf("vec%0d_diff_retained", i), 32'(bus.diff), 32'(vecs[i].d));
    end

    // Backpressure: 0x12 - 0x34 = 0xDE with borrow, held in DONE for 5 cycles
    bus.a = 8'h12;
    bus.b = 8'h34;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("bp_latency", 32'(n), 32'(EXP_LAT));
    for (int k = 0; k < 5; k++) begin
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      bus.in_valid = k[0];
      @(posedge clk); #1;
      chk($sformatf("bp_diff_c%0d", k), 32'(bus.diff), 32'h0DE);
      chk($sformatf("bp_borrow_c%0d", k), 32'(bus.borrow), 32'd1);
      chk($sformatf("bp_in_ready_c%0d", k), 32'(bus.in_ready), 32'd0);
      chk($sformatf("bp_out_valid_c%0d", k), 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    ops_done++;
    $display("op a=12 b=34 backpressure released diff=%02h borrow=%0d", bus.diff, bus.borrow);
    chk("bp_in_ready_after", 32'(bus.in_ready), 32'd1);
    chk("bp_out_valid_after", 32'(bus.out_valid), 32'd0);

    // Reset during the 4th RUN cycle
    bus.a = 8'hA5;
    bus.b = 8'h5A;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    $display("op a=A5 b=5A aborted by reset");
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_borrow", 32'(bus.borrow), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(8'h10, 8'h01, 0, rd, rb, ro, lat);
    chk("post_rst_latency", 32'(lat), 32'(EXP_LAT));
    chk("post_rst_diff", 32'(rd), 32'h0F);
    chk("post_rst_borrow", 32'(rb), 32'd0);

    // Random regression with output stalls
    for (int i = 0; i < 50; i++) begin
      ra  = W'($urandom);
      rbv = W'($urandom);
      e   = {1'b0, ra} - {1'b0, rbv};
      run_op(ra, rbv, $urandom_range(0, 3), rd, rb, ro, lat);
      chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(EXP_LAT));
      chk($sformatf("rnd%0d_result", i), 32'({rb, rd}), 32'(e));
    end

    repeat (2) @(posedge clk);
    #1;
    chk("handshake_count", 32'(hs_cnt), 32'(ops_done));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
